lsu_bus: RTL and testbench
==========================

LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 Parameter TIMEOUT, default 16: bus-wait cycles before a transaction is abandoned; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 MemRead  input  1  load request from the datapath, held until Stall deasserts.
REQ-005 MemWrite  input  1  store request from the datapath, held until Stall deasserts.
REQ-006 Funct3  input  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only.
REQ-007 ALUResult  input  32  byte address from the datapath ALU.
REQ-008 WriteData  input  32  store data from the register file rs2 port.
REQ-009 ReadData  output  32  extended load result, fed to the datapath result mux.
REQ-010 Stall  output  1  freezes the PC register and register-file write while high.
REQ-011 AccessFault  output  1  misaligned or reserved-Funct3 access, or bus timeout.
REQ-012 bus_req  output  1  bus transaction request.
REQ-013 bus_we  output  1  1 = write.
REQ-014 bus_addr  output  32  word address, with bits [1:0] forced to 00.
REQ-015 bus_be  output  4  byte enables; bit n selects byte lane n.
REQ-016 bus_wdata  output  32  lane-replicated store data.
REQ-017 bus_ack  input  1  slave completion, sampled on the rising edge.
REQ-018 bus_rdata  input  32  read word, valid in the bus_ack cycle.

Function
REQ-019 States: IDLE, REQ, DONE; 2-bit encoding; unused encodings return to IDLE.
REQ-020 A request is MemRead|MemWrite; when both are high, the access is a write.
REQ-021 Fault conditions: H/HU with ALUResult[0]=1; W with ALUResult[1:0]!=00; Funct3 in {011,110,111}; a store with Funct3 in {100,101}.
REQ-022 IDLE with a faulting request: AccessFault=1 and Stall=0 combinationally; ReadData=0; no bus transaction; stay in IDLE.
REQ-023 IDLE with a legal request: Stall=1 combinationally; at the edge, latch bus_addr, bus_we, bus_be, bus_wdata, Funct3 and ALUResult[1:0]; assert bus_req; go to REQ.
REQ-024 REQ: Stall=1; bus_req and all bus outputs held stable until bus_ack is sampled high.
REQ-025 REQ with bus_ack=1: capture bus_rdata into the read register; drop bus_req at the same edge; go to DONE.
REQ-026 The wait counter clears on entry to REQ and increments each REQ cycle without bus_ack.
REQ-027 When the wait counter reaches TIMEOUT-1 without bus_ack: drop bus_req, zero the read register, set the timeout flag, go to DONE.
REQ-028 DONE lasts exactly 1 cycle: Stall=0; ReadData valid; AccessFault=timeout flag; then go to IDLE.
REQ-029 bus_ack arriving in the same cycle as the timeout wins: the data is captured and no fault is raised.
REQ-030 Back-to-back memory instructions: the request seen in the IDLE cycle after DONE is a new access and issues normally.
REQ-031 Minimum load/store latency is 3 cycles (IDLE, REQ, DONE) for bus_ack in the first REQ cycle.
REQ-032 bus_be by size and A=ALUResult[1:0]: B = 1<<A; H = 0011 if A[1]=0, else 1100; W = 1111.
REQ-033 bus_wdata: B = {4{WriteData[7:0]}}; H = {2{WriteData[15:0]}}; W = WriteData.
REQ-034 Loads use the latched A to select the lane: B/H sign-extend to 32 bits, BU/HU zero-extend, W passes through.
REQ-035 ReadData is 0 in every cycle other than DONE of a load; bus_ack outside REQ is ignored.

Reset
REQ-036 reset forces IDLE immediately, including mid-transaction.
REQ-037 On reset: bus_req=0, bus_we=0, bus_be=0000, bus_addr=0, bus_wdata=0, read register=0, counter=0, timeout flag=0.
REQ-038 During reset, Stall and AccessFault are 0 regardless of the inputs.

Verification
REQ-039 Scenario, load byte: LB at 0x1003, bus_rdata=0x80FF_0000 with ack in the first REQ cycle -> bus_addr=0x1000, bus_be=1000, DONE ReadData=0xFFFF_FF80, Stall high for exactly 2 cycles.
REQ-040 Scenario, store halfword: SH at 0x2002, WriteData=0x1234_ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCD_ABCD, held stable over a 3-cycle ack delay.
REQ-041 Scenario, misaligned load: LW at 0x0001 -> AccessFault=1 and Stall=0 in the same cycle, bus_req never asserted.
REQ-042 Scenario, timeout: ack withheld with TIMEOUT=4 -> bus_req high for 4 cycles, DONE with AccessFault=1 and ReadData=0; ack on cycle 4 instead -> data captured, no fault.
REQ-043 Scenario, reset in REQ: reset asserted while in REQ -> bus_req falls without waiting for a clock edge; after release, a fresh LBU at 0x0 returns 0x0000_00xx correctly.
REQ-044 Scenario, back-to-back: SW followed by LW -> two complete transactions, a single DONE cycle between them, no lost or duplicated bus_req.

Source files
------------

// File: rtl/lsu_bus.sv
// Load/store unit bridging the datapath to a single-beat request/ack bus.
// One access at a time: IDLE (decode), REQ (wait for ack or timeout), DONE (result).
module lsu_bus #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        AccessFault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic             r_bus_req;
   logic             r_we;
   logic [31:0]      r_addr;
   logic [3:0]       r_be;
   logic [31:0]      r_wdata;
   logic [2:0]       r_f3;
   logic [1:0]       r_a;
   logic [31:0]      r_rd;
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;

   logic             w_req;
   logic             w_is_write;
   logic             w_bad;
   logic [1:0]       w_a;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_load_ext;
   logic             w_stall;
   logic             w_fault;
   logic [31:0]      w_rdata;

   assign w_req      = MemRead | MemWrite;
   assign w_is_write = MemWrite;
   assign w_a        = ALUResult[1:0];

   // Alignment and encoding checks on the incoming request
   always_comb begin
      w_bad = 1'b0;
      case (Funct3)
         3'b000, 3'b100: w_bad = 1'b0;
         3'b001, 3'b101: w_bad = w_a[0];
         3'b010:         w_bad = (w_a != 2'b00);
         default:        w_bad = 1'b1;
      endcase
      if (w_is_write && Funct3[2]) begin
         w_bad = 1'b1;
      end
   end

   // Byte enables and lane-replicated store data from size and low address bits
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = WriteData;
      case (Funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_a;
            w_wdata = {4{WriteData[7:0]}};
         end
         2'b01: begin
            w_be    = w_a[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{WriteData[15:0]}};
         end
         2'b10: begin
            w_be    = 4'b1111;
            w_wdata = WriteData;
         end
         default: begin
            w_be    = 4'b0000;
            w_wdata = WriteData;
         end
      endcase
   end

   // Lane selection and sign/zero extension of the captured read word
   assign w_byte = 8'(r_rd >> {r_a, 3'b000});
   assign w_half = r_a[1] ? r_rd[31:16] : r_rd[15:0];

   always_comb begin
      w_load_ext = 32'h0;
      case (r_f3)
         3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
         3'b010:  w_load_ext = r_rd;
         3'b100:  w_load_ext = {24'h0, w_byte};
         3'b101:  w_load_ext = {16'h0, w_half};
         default: w_load_ext = 32'h0;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and combinational handshake outputs toward the datapath
   always_comb begin
      w_state_next = r_state;
      w_stall      = 1'b0;
      w_fault      = 1'b0;
      w_rdata      = 32'h0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (w_bad) begin
                  w_fault = 1'b1;
               end else begin
                  w_stall      = 1'b1;
                  w_state_next = S_REQ;
               end
            end
         end
         S_REQ: begin
            w_stall = 1'b1;
            if (bus_ack || (r_cnt == CNT_LAST)) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_fault      = r_timeout;
            w_state_next = S_IDLE;
            if (!r_we) begin
               w_rdata = w_load_ext;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Bus request registers, wait counter and read capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bus_req <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= 32'h0;
         r_be      <= 4'b0000;
         r_wdata   <= 32'h0;
         r_f3      <= 3'b000;
         r_a       <= 2'b00;
         r_rd      <= 32'h0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req && !w_bad) begin
                  r_bus_req <= 1'b1;
                  r_we      <= w_is_write;
                  r_addr    <= {ALUResult[31:2], 2'b00};
                  r_be      <= w_be;
                  r_wdata   <= w_wdata;
                  r_f3      <= Funct3;
                  r_a       <= w_a;
                  r_cnt     <= '0;
                  r_timeout <= 1'b0;
               end
            end
            S_REQ: begin
               if (bus_ack) begin
                  r_rd      <= bus_rdata;
                  r_bus_req <= 1'b0;
               end else if (r_cnt == CNT_LAST) begin
                  r_rd      <= 32'h0;
                  r_bus_req <= 1'b0;
                  r_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Datapath-facing outputs are silenced while reset is held
   assign Stall       = w_stall & ~reset;
   assign AccessFault = w_fault & ~reset;
   assign ReadData    = reset ? 32'h0 : w_rdata;

   assign bus_req   = r_bus_req;
   assign bus_we    = r_we;
   assign bus_addr  = r_addr;
   assign bus_be    = r_be;
   assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus with a result scoreboard.
module tb_lsu_bus;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] ALUResult, WriteData;
   logic [31:0] ReadData;
   logic        Stall, AccessFault;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   typedef struct {
      logic [31:0] rd;
      logic        fault;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   lsu_bus #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
      .ALUResult(ALUResult), .WriteData(WriteData),
      .ReadData(ReadData), .Stall(Stall), .AccessFault(AccessFault),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic sb_pop(input string tag);
      exp_t e;
      check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, "_ReadData"}, ReadData, e.rd);
         check({tag, "_AccessFault"}, 32'(AccessFault), 32'(e.fault));
      end
   endtask

   // Starts at posedge+1 with the request driven in the current IDLE cycle;
   // returns at posedge+1 of the following IDLE cycle with the request dropped.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata,
                         input int ack_dly, input logic bad,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rd);
      exp_t e;
      int   stalls;
      int   req_cycles;
      logic timed_out;
      MemRead   = rd;
      MemWrite  = wr;
      Funct3    = f3;
      ALUResult = addr;
      WriteData = wd;
      timed_out = !bad && (ack_dly >= int'(TO));
      e.rd      = (bad || wr || timed_out) ? 32'h0 : exp_rd;
      e.fault   = bad || timed_out;
      sb.push_back(e);
      @(negedge clk);
      check({tag, "_idle_req"}, 32'(bus_req), 32'd0);
      if (bad) begin
         check({tag, "_fault_stall"}, 32'(Stall), 32'd0);
         sb_pop(tag);
         @(posedge clk); #1;
         MemRead = 1'b0; MemWrite = 1'b0;
         @(negedge clk);
         check({tag, "_no_issue"}, 32'(bus_req), 32'd0);
         @(posedge clk); #1;
         return;
      end
      stalls = Stall ? 1 : 0;
      check({tag, "_idle_fault"}, 32'(AccessFault), 32'd0);
      @(posedge clk); #1;
      bus_rdata  = rdata;
      req_cycles = 0;
      for (int k = 0; k < int'(TO); k++) begin
         bus_ack = (k == ack_dly);
         @(negedge clk);
         req_cycles++;
         if (Stall) stalls++;
         check({tag, "_req"}, 32'(bus_req), 32'd1);
         check({tag, "_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
         check({tag, "_be"}, 32'(bus_be), 32'(exp_be));
         check({tag, "_we"}, 32'(bus_we), 32'(wr));
         if (wr) check({tag, "_wdata"}, bus_wdata, exp_wdata);
         check({tag, "_req_rd0"}, ReadData, 32'h0);
         @(posedge clk); #1;
         bus_ack = 1'b0;
         if (k == ack_dly) break;
      end
      check({tag, "_req_cycles"}, 32'(req_cycles), timed_out ? 32'(TO) : 32'(ack_dly + 1));
      @(negedge clk);
      check({tag, "_done_stall"}, 32'(Stall), 32'd0);
      check({tag, "_done_req"}, 32'(bus_req), 32'd0);
      check({tag, "_stall_cycles"}, 32'(stalls), 32'(req_cycles + 1));
      sb_pop(tag);
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h1;
      WriteData = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
      // Reset state, with a faulting then a legal request present
      #7;
      check("rst_fault", 32'(AccessFault), 32'd0);
      check("rst_stall", 32'(Stall), 32'd0);
      ALUResult = 32'h0;
      #1;
      check("rst_stall_legal", 32'(Stall), 32'd0);
      check("rst_req", 32'(bus_req), 32'd0);
      check("rst_we", 32'(bus_we), 32'd0);
      check("rst_be", 32'(bus_be), 32'd0);
      check("rst_addr", bus_addr, 32'h0);
      check("rst_wdata", bus_wdata, 32'h0);
      check("rst_rd", ReadData, 32'h0);
      MemRead = 1'b0;
      @(negedge clk); reset = 1'b0;
      idle(2);

      // bus_ack outside REQ must be ignored
      bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("stray_ack_rd", ReadData, 32'h0);
      check("stray_ack_req", 32'(bus_req), 32'd0);
      @(posedge clk); #1; bus_ack = 1'b0;
      idle(1);

      access("lb", 1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0, 4'b1000, 32'h0, 32'hFFFF_FF80);
      idle(1);
      access("sh", 0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 0, 4'b1100, 32'hABCD_ABCD, 32'h0);
      idle(1);
      access("lw_mis", 1, 0, 3'b010, 32'h0000_0001, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0);
      access("lh_odd", 1, 0, 3'b001, 32'h0000_0003, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0);
      access("rsv_011", 1, 0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0);
      access("sbu_bad", 0, 1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0);
      access("lh_hi", 1, 0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_1234, 1, 0, 4'b1100, 32'h0, 32'hFFFF_8001);
      access("lhu_hi", 1, 0, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_1234, 0, 0, 4'b1100, 32'h0, 32'h0000_8001);
      access("lbu_l1", 1, 0, 3'b100, 32'h0000_0005, 32'h0, 32'h0000_F700, 2, 0, 4'b0010, 32'h0, 32'h0000_00F7);
      // Both strobes high is a write
      access("sb_both", 1, 1, 3'b000, 32'h0000_3001, 32'h0000_005A, 32'h0, 0, 0, 4'b0010, 32'h5A5A_5A5A, 32'h0);
      idle(1);
      access("lw_to", 1, 0, 3'b010, 32'h0000_0020, 32'h0, 32'h1111_2222, 99, 0, 4'b1111, 32'h0, 32'h0);
      access("lw_ack4", 1, 0, 3'b010, 32'h0000_0020, 32'h0, 32'h1111_2222, 3, 0, 4'b1111, 32'h0, 32'h1111_2222);
      idle(1);
      // Back-to-back store then load
      access("sw_b2b", 0, 1, 3'b010, 32'h0000_0100, 32'hCAFE_F00D, 32'h0, 0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0);
      access("lw_b2b", 1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0, 0, 4'b1111, 32'h0, 32'hCAFE_F00D);
      idle(1);

      // Reset asserted mid-REQ
      MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0000_0040;
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_req_up", 32'(bus_req), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_req", 32'(bus_req), 32'd0);
      check("mid_rst_stall", 32'(Stall), 32'd0);
      check("mid_rst_fault", 32'(AccessFault), 32'd0);
      MemRead = 1'b0;
      @(negedge clk); reset = 1'b0;
      idle(1);
      access("lbu_post", 1, 0, 3'b100, 32'h0000_0000, 32'h0, 32'h1122_33A5, 0, 0, 4'b0001, 32'h0, 32'h0000_00A5);
      idle(2);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
